spi_command_interface: RTL and testbench

SPI slave front end that sits directly upstream of the spiking network's parameter/weight memory and the debug readback path. It runs in the system_clock domain and oversamples the pin-level SCLK/MOSI/SS. It decodes opcode/address/data byte frames into single-cycle memory write and read strobes, returns read data on MISO, and pulses spi_instruction_done at the end of each completed transaction.

---
 rtl/spi_command_interface_if.sv | 27 ++
 rtl/spi_command_interface.sv | 185 ++++++++++++++++++
 tb/tb_spi_command_interface.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_command_interface_if.sv
// Pin-level SPI signals plus the memory-side strobe bus of the SPI command front end.
// The master modport drives the pins and read data; the slave modport is the front end.
interface spi_command_interface_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic                  SCLK;
    logic                  MOSI;
    logic                  SS;
    logic                  MISO;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_we;
    logic                  mem_re;
    logic [7:0]            mem_rdata;
    logic                  spi_instruction_done;
    logic                  busy;

    modport master (
        output SCLK, MOSI, SS, mem_rdata,
        input  MISO, mem_addr, mem_wdata, mem_we, mem_re, spi_instruction_done, busy
    );

    modport slave (
        input  SCLK, MOSI, SS, mem_rdata,
        output MISO, mem_addr, mem_wdata, mem_we, mem_re, spi_instruction_done, busy
    );
endinterface

// File: rtl/spi_command_interface.sv
// Oversampling SPI mode-0 slave that decodes opcode/address/data frames into
// single-cycle memory write/read strobes and streams read data back on MISO.
module spi_command_interface #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic                    system_clock,
    input logic                    reset,
    spi_command_interface_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam logic [BYTE_W-1:0] OP_WRITE = 8'h01;
    localparam logic [BYTE_W-1:0] OP_READ  = 8'h02;

    typedef enum logic [2:0] {IDLE, OPCODE, ADDR, WDATA, RDATA, IGNORE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_d;
    logic                   ss_d;
    logic [CNT_W-1:0]       bit_cnt;
    logic [BYTE_W-1:0]      rx;
    logic [BYTE_W-1:0]      tx;
    logic                   is_read;
    logic                   data_seen;
    logic                   armed;
    logic                   rd_next;
    logic                   re_d;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [BYTE_W-1:0]      mem_wdata;
    logic                   mem_we;
    logic                   mem_re;
    logic                   done;
    logic                   busy;

    logic              sclk_s;
    logic              mosi_s;
    logic              ss_s;
    logic              rise;
    logic              fall;
    logic              ss_fall;
    logic              ss_rise;
    logic              byte_done;
    logic              data_byte_done;
    logic [BYTE_W-1:0] byte_in;

    assign sclk_s         = sclk_sync[SYNC_STAGES-1];
    assign mosi_s         = mosi_sync[SYNC_STAGES-1];
    assign ss_s           = ss_sync[SYNC_STAGES-1];
    assign rise           = sclk_s & ~sclk_d;
    assign fall           = ~sclk_s & sclk_d;
    assign ss_fall        = ~ss_s & ss_d;
    assign ss_rise        = ss_s & ~ss_d;
    assign byte_done      = rise && (bit_cnt == CNT_W'(7));
    assign data_byte_done = byte_done && (state == WDATA || state == RDATA);
    assign byte_in        = {rx[BYTE_W-2:0], mosi_s};

    assign bus.MISO                 = tx[BYTE_W-1];
    assign bus.mem_addr             = mem_addr;
    assign bus.mem_wdata            = mem_wdata;
    assign bus.mem_we               = mem_we;
    assign bus.mem_re               = mem_re;
    assign bus.spi_instruction_done = done;
    assign bus.busy                 = busy;

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state     <= IDLE;
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            fill      <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            bit_cnt   <= '0;
            rx        <= '0;
            tx        <= '0;
            is_read   <= 1'b0;
            data_seen <= 1'b0;
            armed     <= 1'b0;
            rd_next   <= 1'b0;
            re_d      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SS};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            busy      <= ~ss_s;
            mem_we    <= 1'b0;
            mem_re    <= rd_next;
            rd_next   <= 1'b0;
            re_d      <= mem_re;
            done      <= 1'b0;

            // Only arm once SS has been seen high from the pin, so a reset mid-frame waits for a fresh select
            if (fill[SYNC_STAGES-1] && ss_s) armed <= 1'b1;

            // Falls after rises 1..7 advance MISO; the fall following a byte boundary leaves the reloaded MSB in place
            if (re_d && state == RDATA)      tx <= bus.mem_rdata;
            else if (fall && bit_cnt != '0)  tx <= {tx[BYTE_W-2:0], 1'b0};

            if (mem_we) mem_addr <= mem_addr + ADDR_WIDTH'(1);

            if (rise && state != IDLE && state != IGNORE) begin
                rx      <= byte_in;
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (ss_fall && armed) begin
                        state     <= OPCODE;
                        bit_cnt   <= '0;
                        rx        <= '0;
                        data_seen <= 1'b0;
                    end
                end
                OPCODE: begin
                    if (byte_done) begin
                        if (byte_in == OPCODE_WRITE_SEL(OP_WRITE)) begin
                            is_read <= 1'b0;
                            state   <= ADDR;
                        end else if (byte_in == OP_READ) begin
                            is_read <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            state   <= IGNORE;
                        end
                    end
                end
                ADDR: begin
                    if (byte_done) begin
                        mem_addr <= ADDR_WIDTH'(byte_in);
                        if (is_read) begin
                            mem_re <= 1'b1;
                            state  <= RDATA;
                        end else begin
                            state  <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (byte_done) begin
                        mem_wdata <= byte_in;
                        mem_we    <= 1'b1;
                        data_seen <= 1'b1;
                    end
                end
                RDATA: begin
                    if (byte_done) begin
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        rd_next   <= 1'b1;
                        data_seen <= 1'b1;
                    end
                end
                IGNORE: ;
                default: state <= IDLE;
            endcase

            // Deselect ends the frame; a byte completing in the same cycle still counts toward done
            if (ss_rise) begin
                state     <= IDLE;
                tx        <= '0;
                data_seen <= 1'b0;
                done      <= data_seen || data_byte_done;
            end
        end
    end

    function automatic logic [BYTE_W-1:0] OPCODE_WRITE_SEL(input logic [BYTE_W-1:0] op);
        return op;
    endfunction
endmodule

// File: tb/tb_spi_command_interface.sv
// Directed and randomized SPI frames checked against a byte-level transaction model.
module tb_spi_command_interface;
    localparam int unsigned ADDR_WIDTH = 8;
    localparam int unsigned HALF       = 8;

    logic system_clock = 1'b0;
    logic reset;

    always #5 system_clock = ~system_clock;

    spi_command_interface_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    spi_command_interface #(.ADDR_WIDTH(ADDR_WIDTH), .SYNC_STAGES(2)) dut (
        .system_clock(system_clock),
        .reset       (reset),
        .bus         (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  txd [0:7];
    logic [15:0] we_q [$];
    logic [7:0]  re_q [$];
    int done_cnt, overlap_cnt, miso_hi_cnt;

    // Memory responder: data valid the cycle after mem_re, noise otherwise
    always @(posedge system_clock) begin
        if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        else            bus.mem_rdata <= 8'($urandom);
    end

    always @(negedge system_clock) begin
        if (!reset) begin
            if (bus.mem_we) we_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.mem_re) re_q.push_back(bus.mem_addr);
            if (bus.spi_instruction_done) done_cnt++;
            if (bus.mem_we && bus.mem_re) overlap_cnt++;
            if (bus.MISO) miso_hi_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge system_clock);
    endtask

    task automatic clear_log();
        we_q.delete();
        re_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
        miso_hi_cnt = 0;
    endtask

    task automatic spi_bit(input logic b, output logic s);
        bus.MOSI = b;
        wait_clk(HALF);
        s = bus.MISO;
        bus.SCLK = 1'b1;
        wait_clk(HALF);
        bus.SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v, output logic [7:0] r);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(v[i], s);
            r[i] = s;
        end
    endtask

    // One framed transaction: opcode, address, ndata full bytes, then 'partial' stray bits
    task automatic run_txn(input logic [7:0] op, input logic [7:0] addr, input int ndata, input int partial);
        logic [7:0] rx;
        logic [7:0] miso_b [0:7];
        logic       s;
        bit         is_wr, is_rd;
        clear_log();
        bus.SS = 1'b0;
        wait_clk(HALF);
        chk("busy_during_select", 32'(bus.busy), 32'd1);
        spi_byte(op, rx);
        spi_byte(addr, rx);
        for (int i = 0; i < ndata; i++) spi_byte(txd[i], miso_b[i]);
        for (int i = 0; i < partial; i++) spi_bit(1'($urandom), s);
        wait_clk(HALF);
        bus.SS = 1'b1;
        wait_clk(4 * HALF);
        chk("busy_after_deselect", 32'(bus.busy), 32'd0);

        is_wr = (op == 8'h01);
        is_rd = (op == 8'h02);
        chk("we_count", 32'(we_q.size()), is_wr ? 32'(ndata) : 32'd0);
        if (is_wr) begin
            for (int i = 0; i < ndata && i < we_q.size(); i++) begin
                chk("we_addr", 32'(we_q[i][15:8]), 32'((int'(addr) + i) % 256));
                chk("we_data", 32'(we_q[i][7:0]), 32'(txd[i]));
            end
        end
        chk("re_count", 32'(re_q.size()), is_rd ? 32'(ndata + 1) : 32'd0);
        if (is_rd) begin
            for (int i = 0; i <= ndata && i < re_q.size(); i++)
                chk("re_addr", 32'(re_q[i]), 32'((int'(addr) + i) % 256));
            for (int i = 0; i < ndata; i++)
                chk("miso_byte", 32'(miso_b[i]), 32'(mem[(int'(addr) + i) % 256]));
        end else begin
            chk("miso_quiet", 32'(miso_hi_cnt), 32'd0);
        end
        chk("done_count", 32'(done_cnt), ((is_wr || is_rd) && ndata > 0) ? 32'd1 : 32'd0);
        chk("we_re_overlap", 32'(overlap_cnt), 32'd0);
        wait_clk(2 * HALF);
    endtask

    initial begin
        logic [7:0] rx, op, ad;
        logic       s;
        int         kind, nd, pb;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        bus.SS   = 1'b1;
        reset    = 1'b1;
        clear_log();
        wait_clk(4);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("rst_miso", 32'(bus.MISO), 32'd0);
        chk("rst_done", 32'(bus.spi_instruction_done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b0;
        wait_clk(4 * HALF);

        // Single write
        txd[0] = 8'hA5;
        run_txn(8'h01, 8'h10, 1, 0);

        // Burst write across the address wrap
        txd[0] = 8'h11; txd[1] = 8'h22; txd[2] = 8'h33;
        run_txn(8'h01, 8'hFE, 3, 0);

        // Single read
        mem[8'h20] = 8'h3C;
        txd[0] = 8'h00;
        run_txn(8'h02, 8'h20, 1, 0);

        // Aborted write then a normal one
        run_txn(8'h01, 8'h40, 0, 5);
        txd[0] = 8'h77;
        run_txn(8'h01, 8'h41, 1, 0);

        // Unknown opcode
        txd[0] = 8'h55;
        run_txn(8'h7E, 8'h10, 1, 0);

        // Reset in the middle of a data byte
        clear_log();
        bus.SS = 1'b0;
        wait_clk(HALF);
        spi_byte(8'h01, rx);
        spi_byte(8'h30, rx);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, s);
        reset = 1'b1;
        @(negedge system_clock);
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mem_re", 32'(bus.mem_re), 32'd0);
        chk("midrst_miso", 32'(bus.MISO), 32'd0);
        chk("midrst_done", 32'(bus.spi_instruction_done), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
        reset = 1'b0;
        clear_log();
        for (int i = 0; i < 12; i++) spi_bit(1'($urandom), s);
        wait_clk(HALF);
        bus.SS = 1'b1;
        wait_clk(4 * HALF);
        chk("postrst_we_count", 32'(we_q.size()), 32'd0);
        chk("postrst_re_count", 32'(re_q.size()), 32'd0);
        chk("postrst_done", 32'(done_cnt), 32'd0);
        txd[0] = 8'h5A;
        run_txn(8'h01, 8'h30, 1, 0);

        // Randomized frames
        for (int t = 0; t < 10; t++) begin
            kind = int'($urandom_range(0, 2));
            op   = (kind == 0) ? 8'h01 : (kind == 1) ? 8'h02 : 8'($urandom_range(3, 255));
            ad   = 8'($urandom);
            nd   = int'($urandom_range(0, 3));
            pb   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            for (int i = 0; i < 8; i++) txd[i] = 8'($urandom);
            run_txn(op, ad, nd, pb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
